// File: rtl/icache_fill_ctrl_pkg.sv
// Shared types for the icache fill path: memory command encodings, MSHR entry states,
// and the line-address helper used for every MSHR compare.
package icache_fill_ctrl_pkg;

    localparam logic [1:0] MEM_NONE = 2'd0;
    localparam logic [1:0] MEM_LOAD = 2'd1;

    localparam int LINE_W = 61;
    typedef logic [LINE_W-1:0] line_t;

    typedef enum logic [1:0] {
        MSHR_FREE  = 2'd0,
        MSHR_ISSUE = 2'd1,
        MSHR_WAIT  = 2'd2
    } mshr_state_t;

    function automatic line_t line_of(input logic [63:0] addr);
        return addr[63:3];
    endfunction

endpackage

// File: rtl/icache_mshr_entry.sv
// One MSHR slot: FREE -> ISSUE on alloc, ISSUE -> WAIT on accept (tag latched), WAIT -> FREE on fill.
// Match outputs are combinational; state changes at the clock edge.
module icache_mshr_entry
    import icache_fill_ctrl_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        alloc,
    input  line_t       alloc_line,
    input  logic        accept,
    input  logic [3:0]  accept_tag,
    input  logic        fill,
    input  line_t       lookup_line,
    input  line_t       pf_line,
    input  logic [3:0]  rsp_tag,
    output logic        is_free,
    output logic        is_issue,
    output logic        lookup_hit,
    output logic        pf_hit,
    output logic        tag_hit,
    output line_t       line
);

    mshr_state_t state_q, state_d;
    line_t       line_q;
    logic [3:0]  tag_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            MSHR_FREE:  if (alloc)  state_d = MSHR_ISSUE;
            MSHR_ISSUE: if (accept) state_d = MSHR_WAIT;
            MSHR_WAIT:  if (fill)   state_d = MSHR_FREE;
            default:                state_d = MSHR_FREE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= MSHR_FREE;
            line_q  <= '0;
            tag_q   <= '0;
        end else begin
            state_q <= state_d;
            if (alloc && state_q == MSHR_FREE)
                line_q <= alloc_line;
            if (accept && state_q == MSHR_ISSUE)
                tag_q <= accept_tag;
        end
    end

    assign is_free    = (state_q == MSHR_FREE);
    assign is_issue   = (state_q == MSHR_ISSUE);
    assign lookup_hit = !is_free && (line_q == lookup_line);
    assign pf_hit     = !is_free && (line_q == pf_line);
    assign tag_hit    = (state_q == MSHR_WAIT) && (rsp_tag != 4'd0) && (rsp_tag == tag_q);
    assign line       = line_q;

endmodule

// File: rtl/icache_fill_ctrl.sv
// Icache miss/fill controller: cache lookup, MSHR allocation, memory issue, fill and sequential prefetch.
// Hit/forward/fill outputs are combinational; a new miss is issued to memory the cycle after allocation.
module icache_fill_ctrl
    import icache_fill_ctrl_pkg::*;
#(
    parameter int NUM_MSHR = 4,
    parameter int PF_DEPTH = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [63:0] proc2Icache_addr,
    output logic [63:0] Icache_data_out,
    output logic        Icache_valid_out,
    output logic [63:0] cache_rd_pc_reg,
    input  logic [63:0] cache_rd_data,
    input  logic        cache_rd_valid,
    output logic        cache_wr_en,
    output logic [63:0] cache_wr_data,
    output logic [63:0] cache_wr_pc_reg,
    output logic [1:0]  proc2Imem_command,
    output logic [63:0] proc2Imem_addr,
    input  logic [3:0]  Imem2proc_response,
    input  logic [63:0] Imem2proc_data,
    input  logic [3:0]  Imem2proc_tag
);

    localparam int IDX_W = $clog2(NUM_MSHR);
    localparam int PF_CW = $clog2(PF_DEPTH + 2);

    line_t fetch_line;
    logic  unused_addr_bits;
    assign fetch_line       = line_of(proc2Icache_addr);
    assign unused_addr_bits = ^proc2Icache_addr[2:0];
    assign cache_rd_pc_reg  = {fetch_line, 3'b000};

    logic [NUM_MSHR-1:0] is_free, is_issue, lookup_hit, pf_hit, tag_hit;
    logic [NUM_MSHR-1:0] alloc_v, accept_v, fill_v;
    line_t               ent_line [NUM_MSHR];
    line_t               pf_line, alloc_line;
    logic [PF_CW-1:0]    pf_cnt;

    logic [IDX_W-1:0] free_idx, issue_idx, fill_idx;
    logic             any_free, any_issue, any_fill;
    logic             hit, fwd, demand_alloc, pf_active, pf_skip, pf_alloc;

    for (genvar g = 0; g < NUM_MSHR; g++) begin : g_mshr
        icache_mshr_entry u_entry (
            .clock       (clock),
            .reset       (reset),
            .alloc       (alloc_v[g]),
            .alloc_line  (alloc_line),
            .accept      (accept_v[g]),
            .accept_tag  (Imem2proc_response),
            .fill        (fill_v[g]),
            .lookup_line (fetch_line),
            .pf_line     (pf_line),
            .rsp_tag     (Imem2proc_tag),
            .is_free     (is_free[g]),
            .is_issue    (is_issue[g]),
            .lookup_hit  (lookup_hit[g]),
            .pf_hit      (pf_hit[g]),
            .tag_hit     (tag_hit[g]),
            .line        (ent_line[g])
        );
    end

    // Lowest-index priority encoders; descending loop lets the lowest match win.
    always_comb begin
        free_idx  = '0;
        issue_idx = '0;
        fill_idx  = '0;
        for (int i = NUM_MSHR - 1; i >= 0; i--) begin
            if (is_free[i])  free_idx  = IDX_W'(i);
            if (is_issue[i]) issue_idx = IDX_W'(i);
            if (tag_hit[i])  fill_idx  = IDX_W'(i);
        end
    end

    assign any_free  = |is_free;
    assign any_issue = !reset && (|is_issue);
    assign any_fill  = !reset && (|tag_hit);

    // Entries are still live during the reset cycle, so every action is gated by reset.
    assign hit          = cache_rd_valid;
    assign fwd          = !reset && !hit && (|(tag_hit & lookup_hit));
    assign demand_alloc = !reset && !hit && !fwd && !(|lookup_hit) && any_free;
    assign pf_active    = !reset && !demand_alloc && (pf_cnt != '0);
    assign pf_skip      = pf_active && (|pf_hit);
    assign pf_alloc     = pf_active && !(|pf_hit) && any_free;
    assign alloc_line   = demand_alloc ? fetch_line : pf_line;

    always_comb begin
        alloc_v  = '0;
        accept_v = '0;
        fill_v   = '0;
        if (demand_alloc || pf_alloc)
            alloc_v[free_idx] = 1'b1;
        if (any_issue && Imem2proc_response != 4'd0)
            accept_v[issue_idx] = 1'b1;
        if (any_fill)
            fill_v[fill_idx] = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pf_cnt  <= '0;
            pf_line <= '0;
        end else if (demand_alloc) begin
            pf_cnt  <= PF_CW'(PF_DEPTH);
            pf_line <= fetch_line + 1'b1;
        end else if (pf_skip || pf_alloc) begin
            pf_cnt  <= pf_cnt - 1'b1;
            pf_line <= pf_line + 1'b1;
        end
    end

    assign Icache_valid_out  = hit || fwd;
    assign Icache_data_out   = hit ? cache_rd_data : (fwd ? Imem2proc_data : 64'd0);
    assign proc2Imem_command = any_issue ? MEM_LOAD : MEM_NONE;
    assign proc2Imem_addr    = any_issue ? {ent_line[issue_idx], 3'b000} : 64'd0;
    assign cache_wr_en       = any_fill;
    assign cache_wr_data     = any_fill ? Imem2proc_data : 64'd0;
    assign cache_wr_pc_reg   = any_fill ? {ent_line[fill_idx], 3'b000} : 64'd0;

endmodule
